// File: rtl/car_seq_pkg.sv
// Shared types and constants for the car-pass sequence generator.
// The state enum, the {a,b} sensor patterns and the direction encoding live here.
package car_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_e;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

  localparam logic DIR_ENTRY = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  // Entry walks A -> both -> B; exit walks the mirror image B -> both -> A.
  function automatic logic [1:0] ab_pattern(input state_e st, input logic dir);
    logic [1:0] ab;
    ab = AB_NONE;
    case (st)
      P1:      ab = (dir == DIR_ENTRY) ? AB_A : AB_B;
      P2:      ab = AB_BOTH;
      P3:      ab = (dir == DIR_ENTRY) ? AB_B : AB_A;
      default: ab = AB_NONE;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 16-bit loadable down-counter that times each sequence phase.
// Counts down to zero and holds there; expired flags the last cycle of a phase.
module phase_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] value,
  output logic        expired
);

  logic [15:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= 16'd0;
    end else if (load) begin
      value_q <= load_value;
    end else if (value_q != 16'd0) begin
      value_q <= value_q - 16'd1;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == 16'd0);

endmodule

// File: rtl/car_sequence_gen.sv
// Emulates a car passing two beam sensors: emits a timed {a,b} phase sequence
// for an entry or exit on request, and counts completed sequences per direction.
module car_sequence_gen
  import car_seq_pkg::*;
#(
  parameter int PHASE_CYCLES = 10,
  parameter int GAP_CYCLES   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] entries_sent,
  output logic [7:0] exits_sent
);

  // Timer is loaded with N-1 so a phase spans N cycles including the expiry cycle.
  localparam logic [15:0] PHASE_LOAD = 16'(PHASE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        dir_q, dir_d;
  logic [1:0]  ab_q, ab_d;
  logic        done_q, done_d;
  logic [7:0]  entries_q, entries_d;
  logic [7:0]  exits_q, exits_d;

  logic        timer_load;
  logic [15:0] timer_load_value;
  logic [15:0] timer_value;
  logic        timer_expired;

  phase_timer u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      ab_q      <= AB_NONE;
      done_q    <= 1'b0;
      entries_q <= 8'd0;
      exits_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ab_q      <= ab_d;
      done_q    <= done_d;
      entries_q <= entries_d;
      exits_q   <= exits_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    entries_d = entries_q;
    exits_d   = exits_q;

    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here, so start always wins.
        if (start) begin
          dir_d   = dir;
          state_d = P1;
        end
      end
      P1: begin
        if (abort)              state_d = IDLE;
        else if (timer_expired) state_d = P2;
      end
      P2: begin
        if (abort)              state_d = IDLE;
        else if (timer_expired) state_d = P3;
      end
      P3: begin
        if (abort)              state_d = IDLE;
        else if (timer_expired) state_d = GAP;
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer_expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (dir_q == DIR_ENTRY) entries_d = entries_q + 8'd1;
          else                    exits_d   = exits_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ab_d       = ab_pattern(state_d, dir_d);
    timer_load = (state_d != state_q);
    case (state_d)
      P1, P2, P3: timer_load_value = PHASE_LOAD;
      GAP:        timer_load_value = GAP_LOAD;
      default:    timer_load_value = 16'd0;
    endcase
  end

  assign a            = ab_q[1];
  assign b            = ab_q[0];
  assign ready        = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign entries_sent = entries_q;
  assign exits_sent   = exits_q;

endmodule

// File: tb/tb_car_sequence_gen.sv
// Bench for car_sequence_gen: sequence-position reference model checked every
// cycle, plus directed scenarios with literal expectations and random traffic.
module tb_car_sequence_gen;

  localparam int P     = 4;
  localparam int G     = 2;
  localparam int TOTAL = 3 * P + G;

  logic       clk = 1'b0;
  logic       reset, start, dir, abort;
  logic       a, b, ready, busy, done;
  logic [7:0] entries_sent, exits_sent;

  int vectors = 0;
  int errors  = 0;

  car_sequence_gen #(.PHASE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dir          (dir),
    .abort        (abort),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .entries_sent (entries_sent),
    .exits_sent   (exits_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is just a position counter since start.
  bit m_active;
  int m_pos;
  bit m_dir;
  bit m_done;
  int m_ent, m_ext;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_dir    <= 1'b0;
      m_done   <= 1'b0;
      m_ent    <= 0;
      m_ext    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_pos    <= 0;
          m_dir    <= dir;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (m_pos + 1 == TOTAL) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        if (m_dir) m_ent <= (m_ent + 1) % 256;
        else       m_ext <= (m_ext + 1) % 256;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic [1:0] model_ab();
    int ph;
    if (!m_active || m_pos >= 3 * P) return 2'b00;
    ph = m_pos / P;
    if (ph == 1) return 2'b11;
    if ((ph == 0) == m_dir) return 2'b10;
    return 2'b01;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("ab",      {14'd0, a, b},            {14'd0, model_ab()});
      chk("ready",   {15'd0, ready},           {15'd0, !m_active});
      chk("busy",    {15'd0, busy},            {15'd0, m_active});
      chk("done",    {15'd0, done},            {15'd0, m_done});
      chk("entries", {8'd0, entries_sent},     16'(m_ent));
      chk("exits",   {8'd0, exits_sent},       16'(m_ext));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Launches one sequence and records {a,b} for the following cycles.
  task automatic run_seq(input logic d, output logic [1:0] seq [0:15],
                         output int busy_cnt, output int done_cnt);
    start = 1'b1;
    dir   = d;
    step();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      seq[i] = {a, b};
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      step();
    end
  endtask

  initial begin
    logic [1:0] seq [0:15];
    int bc, dc, n, wrap_busy;
    logic [7:0] e0, x0;

    reset = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    do_reset();
    chk("rst_ready",   {15'd0, ready}, 16'd1);
    chk("rst_ab",      {14'd0, a, b},  16'd0);
    chk("rst_entries", {8'd0, entries_sent}, 16'd0);

    // Entry
    run_seq(1'b1, seq, bc, dc);
    chk("entry_p1_first", {14'd0, seq[0]},  16'b10);
    chk("entry_p1_last",  {14'd0, seq[3]},  16'b10);
    chk("entry_p2",       {14'd0, seq[4]},  16'b11);
    chk("entry_p3",       {14'd0, seq[8]},  16'b01);
    chk("entry_p3_last",  {14'd0, seq[11]}, 16'b01);
    chk("entry_gap",      {14'd0, seq[12]}, 16'b00);
    chk("entry_busy_len", 16'(bc), 16'd14);
    chk("entry_done_cnt", 16'(dc), 16'd1);
    chk("entry_count",    {8'd0, entries_sent}, 16'd1);

    // Exit
    run_seq(1'b0, seq, bc, dc);
    chk("exit_p1", {14'd0, seq[0]}, 16'b01);
    chk("exit_p2", {14'd0, seq[5]}, 16'b11);
    chk("exit_p3", {14'd0, seq[9]}, 16'b10);
    chk("exit_count",  {8'd0, exits_sent},   16'd1);
    chk("exit_entries",{8'd0, entries_sent}, 16'd1);

    // Abort on the 2nd cycle of P2
    start = 1'b1; dir = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ab",    {14'd0, a, b}, 16'd0);
    chk("abort_ready", {15'd0, ready}, 16'd1);
    dc = 0;
    repeat (12) begin
      if (done) dc++;
      step();
    end
    chk("abort_no_done", 16'(dc), 16'd0);
    chk("abort_entries", {8'd0, entries_sent}, 16'd1);

    // Start pulse during P3 of an entry is ignored
    start = 1'b1; dir = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1; dir = 1'b0;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("overlap_entries", {8'd0, entries_sent}, 16'd2);
    chk("overlap_exits",   {8'd0, exits_sent},   16'd1);
    chk("overlap_idle",    {15'd0, ready},       16'd1);

    // 256 back-to-back entries wrap the counter
    do_reset();
    start = 1'b1; dir = 1'b1;
    wrap_busy = 0;
    for (int k = 0; k < 256; k++) begin
      n = 0;
      do begin
        step();
        n++;
        if (busy) wrap_busy++;
      end while (!done && n < 20);
      chk("wrap_done_seen", {15'd0, done}, 16'd1);
      chk("wrap_period", 16'(n), 16'd15);
      if (k == 0) chk("wrap_first", {8'd0, entries_sent}, 16'd1);
      if (k == 255) start = 1'b0;
    end
    step();
    chk("wrap_entries", {8'd0, entries_sent}, 16'd0);
    chk("wrap_busy_total", 16'(wrap_busy), 16'(256 * 14));
    chk("wrap_stopped", {15'd0, ready}, 16'd1);

    // Closed loop: 2 entries, 1 exit, then reset mid-P2
    do_reset();
    run_seq(1'b1, seq, bc, dc);
    run_seq(1'b1, seq, bc, dc);
    run_seq(1'b0, seq, bc, dc);
    chk("loop_net", 16'(int'(entries_sent) - int'(exits_sent)), 16'd1);
    start = 1'b1; dir = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_ab",    {14'd0, a, b}, 16'd0);
    chk("midrst_ready", {15'd0, ready}, 16'd1);
    chk("midrst_done",  {15'd0, done},  16'd0);
    chk("midrst_cnt",   {8'd0, entries_sent}, 16'd0);
    start = 1'b1; dir = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    start = 1'b0;
    chk("first_start", {14'd0, a, b}, 16'b01);
    repeat (TOTAL + 2) step();

    // Random traffic
    e0 = entries_sent;
    x0 = exits_sent;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      dir   = $urandom_range(0, 1) == 1;
      abort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    start = 1'b0; abort = 1'b0;
    repeat (TOTAL + 2) step();
    chk("rand_settled", {15'd0, ready}, 16'd1);
    if (e0 == entries_sent && x0 == exits_sent)
      $display("note: random phase left counters unchanged");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
